ps2_rx: RTL and testbench

PS/2 device-to-host receiver and scan-code decoder for the pong top level. It samples the board's `ps2_clk`/`ps2_data` lines, which are only read and never driven here, and deframes 11-bit PS/2 frames into bytes. It then folds the set-2 `E0`/`F0` prefixes into one key event per keypress or keyrelease. Paddle-control logic consumes `key_valid`/`key_code`/`key_ext`/`key_release` in the 100 MHz `clk` domain.

---
 rtl/ps2_rx.sv | 187 ++++++++++++++++++
 tb/tb_ps2_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver plus set-2 scan-code prefix folding.
//
// Ports:
//   clk          system clock; all logic runs on its rising edge
//   reset        asynchronous, active-low reset
//   ps2_clk      raw PS/2 clock (asynchronous, input only)
//   ps2_data     raw PS/2 data (asynchronous, input only)
//   data_out     last correctly received byte
//   data_valid   one-cycle pulse; data_out is updated in the same cycle
//   parity_err   one-cycle pulse on bad odd parity
//   frame_err    one-cycle pulse on a bad stop bit or an inter-bit timeout
//   key_code     scan code with the E0/F0 prefixes stripped
//   key_ext      key event was E0-prefixed
//   key_release  key event was F0-prefixed (break)
//   key_valid    one-cycle pulse; key_* are updated in the same cycle
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_valid
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_N = FW'(FILTER_LEN);
  localparam logic [TW-1:0] TO_N  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_e;

  // Input conditioning
  logic          ck_s1_q, ck_s2_q, dt_s1_q, dt_s2_q;
  logic          filt_q;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          bit_edge;

  // Frame FSM
  state_e        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    sh_q;
  logic          par_q, stop_q, chk_q;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Output and decoder registers
  logic [7:0]    data_out_q, key_code_q;
  logic          data_valid_q, parity_err_q, frame_err_q;
  logic          key_ext_q, key_release_q, key_valid_q;
  logic          ext_pend_q, rel_pend_q;

  always_comb begin
    flt_cnt_d = flt_cnt_q + FW'(1);
    to_cnt_d  = to_cnt_q + TW'(1);
    // The filtered clock falls on the same cycle the count completes, so the
    // bit edge is decoded combinationally and data is sampled on that edge.
    bit_edge  = (ck_s2_q != filt_q) && (flt_cnt_d == FLT_N) && !ck_s2_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ck_s1_q   <= 1'b1;
      ck_s2_q   <= 1'b1;
      dt_s1_q   <= 1'b1;
      dt_s2_q   <= 1'b1;
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
    end else begin
      ck_s1_q <= ps2_clk;
      ck_s2_q <= ck_s1_q;
      dt_s1_q <= ps2_data;
      dt_s2_q <= dt_s1_q;
      if (ck_s2_q == filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_d == FLT_N) begin
        filt_q    <= ck_s2_q;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      sh_q          <= '0;
      par_q         <= 1'b0;
      stop_q        <= 1'b0;
      chk_q         <= 1'b0;
      to_cnt_q      <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      key_code_q    <= '0;
      key_ext_q     <= 1'b0;
      key_release_q <= 1'b0;
      key_valid_q   <= 1'b0;
      ext_pend_q    <= 1'b0;
      rel_pend_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      key_valid_q  <= 1'b0;
      chk_q        <= 1'b0;

      if (state_q == S_IDLE || bit_edge) to_cnt_q <= '0;
      else                               to_cnt_q <= to_cnt_d;

      case (state_q)
        S_IDLE: if (bit_edge && !dt_s2_q) begin
          state_q   <= S_DATA;
          bit_cnt_q <= '0;
        end
        S_DATA: if (bit_edge) begin
          sh_q      <= {dt_s2_q, sh_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_q <= S_PAR;
        end
        S_PAR: if (bit_edge) begin
          par_q   <= dt_s2_q;
          state_q <= S_STOP;
        end
        S_STOP: if (bit_edge) begin
          stop_q  <= dt_s2_q;
          chk_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Inter-bit timeout overrides whatever the case above chose.
      if (state_q != S_IDLE && !bit_edge && to_cnt_d == TO_N) begin
        frame_err_q <= 1'b1;
        state_q     <= S_IDLE;
      end

      // Evaluation happens one cycle after the stop edge, always in IDLE,
      // so it never collides with the timeout path.
      if (chk_q) begin
        parity_err_q <= ~^{sh_q, par_q};
        if (!stop_q) frame_err_q <= 1'b1;
        if ((^{sh_q, par_q}) && stop_q) begin
          data_out_q   <= sh_q;
          data_valid_q <= 1'b1;
        end
      end

      // Prefix folding: E0/F0 only arm flags; any other byte emits the event.
      if (data_valid_q) begin
        if (data_out_q == 8'hE0) begin
          ext_pend_q <= 1'b1;
        end else if (data_out_q == 8'hF0) begin
          rel_pend_q <= 1'b1;
        end else begin
          key_valid_q   <= 1'b1;
          key_code_q    <= data_out_q;
          key_ext_q     <= ext_pend_q;
          key_release_q <= rel_pend_q;
          ext_pend_q    <= 1'b0;
          rel_pend_q    <= 1'b0;
        end
      end
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_release = key_release_q;
  assign key_valid   = key_valid_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: drives PS/2 frames with randomized bit periods and bytes,
// records every output pulse with its cycle stamp, and compares against a
// byte/event-level model of framing, parity and prefix folding.
module tb_ps2_rx;
  localparam int FL = 8;
  localparam int TO = 400;

  logic       clk = 1'b0;
  logic       reset, ps2_clk, ps2_data;
  logic [7:0] data_out, key_code;
  logic       data_valid, parity_err, frame_err, key_ext, key_release, key_valid;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .key_code(key_code), .key_ext(key_ext),
    .key_release(key_release), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder, sampled away from the active edge
  int         dv_cyc[$], pe_cyc[$], fe_cyc[$], kv_cyc[$];
  logic [7:0] dv_dat[$];
  logic [9:0] kv_val[$];
  always @(negedge clk) begin
    if (data_valid) begin dv_cyc.push_back(cyc); dv_dat.push_back(data_out); end
    if (parity_err) pe_cyc.push_back(cyc);
    if (frame_err)  fe_cyc.push_back(cyc);
    if (key_valid) begin kv_cyc.push_back(cyc); kv_val.push_back({key_ext, key_release, key_code}); end
  end

  int   npass = 0, nfail = 0, ntot = 0;
  logic ext_m, rel_m;  // model prefix state

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    dv_cyc.delete(); dv_dat.delete(); pe_cyc.delete();
    fe_cyc.delete(); kv_cyc.delete(); kv_val.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit badpar, input bit stop);
    logic p;
    p = (~^b) ^ badpar;  // odd parity over data+parity
    return {stop, p, b, 1'b0};
  endfunction

  // Sends bits[0..n-1]; c_last is the cycle stamp when the last ps2_clk
  // falling level was driven (the next posedge first samples it low).
  task automatic send(input logic [10:0] bits, input int n, input int half, output int c_last);
    c_last = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); ps2_data = bits[i];
      repeat (half) @(negedge clk);
      ps2_clk = 1'b0; c_last = cyc;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] b, input bit badpar,
                       input bit stop, input int half);
    int c; bit good; bit exp_key; logic [9:0] ek;
    clear_q();
    send(mk(b, badpar, stop), 11, half, c);
    ps2_data = 1'b1;
    idle(20);
    good = !badpar && stop;
    chk({tag, ".dv_n"}, 32'(dv_cyc.size()), 32'(good));
    chk({tag, ".pe_n"}, 32'(pe_cyc.size()), 32'(badpar));
    chk({tag, ".fe_n"}, 32'(fe_cyc.size()), 32'(!stop));
    if (dv_cyc.size() > 0) begin
      chk({tag, ".data"}, 32'(dv_dat[0]), 32'(b));
      chk({tag, ".dv_t"}, 32'(dv_cyc[0]), 32'(c + 3 + FL));
    end
    if (pe_cyc.size() > 0) chk({tag, ".pe_t"}, 32'(pe_cyc[0]), 32'(c + 3 + FL));
    if (fe_cyc.size() > 0) chk({tag, ".fe_t"}, 32'(fe_cyc[0]), 32'(c + 3 + FL));
    exp_key = 1'b0; ek = '0;
    if (good) begin
      if (b == 8'hE0)      ext_m = 1'b1;
      else if (b == 8'hF0) rel_m = 1'b1;
      else begin
        exp_key = 1'b1; ek = {ext_m, rel_m, b};
        ext_m = 1'b0; rel_m = 1'b0;
      end
    end
    chk({tag, ".kv_n"}, 32'(kv_cyc.size()), 32'(exp_key));
    if (exp_key && kv_cyc.size() > 0) begin
      chk({tag, ".key"},  32'(kv_val[0]), 32'(ek));
      chk({tag, ".kv_t"}, 32'(kv_cyc[0]), 32'(c + 4 + FL));
    end
  endtask

  initial begin
    int c;
    logic [7:0] b;
    int r;
    reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    ext_m = 1'b0; rel_m = 1'b0;
    idle(3);
    chk("rst.data_out", 32'(data_out), 32'h0);
    chk("rst.key_code", 32'(key_code), 32'h0);
    chk("rst.pulses", 32'({data_valid, parity_err, frame_err, key_valid, key_ext, key_release}), 32'h0);
    reset = 1'b1;
    idle(5);

    // Make code and extended break sequence
    frame("make", 8'h1C, 1'b0, 1'b1, 25);
    frame("e0",   8'hE0, 1'b0, 1'b1, $urandom_range(20, 60));
    frame("f0",   8'hF0, 1'b0, 1'b1, $urandom_range(20, 60));
    frame("k75",  8'h75, 1'b0, 1'b1, $urandom_range(20, 60));
    frame("k1c",  8'h1C, 1'b0, 1'b1, $urandom_range(20, 60));

    // Parity / stop errors
    frame("badpar",  8'h1C, 1'b1, 1'b1, 30);
    frame("badstop", 8'h1C, 1'b0, 1'b0, 30);
    frame("both",    8'h1C, 1'b1, 1'b0, 30);

    // Short clock glitch with data low must not start a frame
    clear_q();
    @(negedge clk); ps2_data = 1'b0; ps2_clk = 1'b0;
    repeat (FL - 1) @(negedge clk);
    ps2_clk = 1'b1;
    idle(30);
    ps2_data = 1'b1;
    // False start: an edge with data high stays in IDLE
    send(11'h7FF, 1, 30, c);
    idle(30);
    chk("glitch.quiet", 32'(dv_cyc.size() + pe_cyc.size() + fe_cyc.size()), 32'h0);
    frame("glitch29", 8'h29, 1'b0, 1'b1, 30);

    // Timeout after start + 4 data bits; measured from the last bit edge
    clear_q();
    send(mk(8'h29, 1'b0, 1'b1), 5, 30, c);
    ps2_data = 1'b1;
    idle(TO + 50);
    chk("to.fe_n", 32'(fe_cyc.size()), 32'h1);
    if (fe_cyc.size() > 0) chk("to.fe_t", 32'(fe_cyc[0]), 32'(c + 2 + FL + TO));
    chk("to.dv_n", 32'(dv_cyc.size() + pe_cyc.size()), 32'h0);
    frame("after_to", 8'h29, 1'b0, 1'b1, 30);

    // Randomized bytes, prefixes and error injection
    for (int i = 0; i < 12; i++) begin
      r = $urandom_range(0, 5);
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom);
      frame("rand", b, ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) != 0),
            $urandom_range(20, 60));
    end

    // Reset mid-frame with a pending F0
    frame("pre_f0", 8'hF0, 1'b0, 1'b1, 30);
    clear_q();
    send(mk(8'h29, 1'b0, 1'b1), 5, 30, c);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid.data_out", 32'(data_out), 32'h0);
    chk("mid.key_code", 32'(key_code), 32'h0);
    chk("mid.pulses", 32'({data_valid, parity_err, frame_err, key_valid, key_ext, key_release}), 32'h0);
    ext_m = 1'b0; rel_m = 1'b0;
    idle(5);
    reset = 1'b1; ps2_data = 1'b1;
    idle(5);
    frame("post_rst", 8'h1C, 1'b0, 1'b1, 30);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
